// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_pkg
// Description : Shared sizing constants, lane types and helper functions for
//               the fifo_drain read-side consumer.
//               IN_DEPTH lanes per bundle, WIDTH bits per raw lane (MSB is the
//               lane-valid flag), OUT_WIDTH lanes issued per cycle at most.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_drain_pkg;

    localparam int IN_DEPTH  = 6;
    localparam int WIDTH     = 32;
    localparam int OUT_WIDTH = 3;

    // Counter width for hold_cnt / hold_ptr (values 0..IN_DEPTH).
    localparam int CNT_W  = $clog2(IN_DEPTH + 1);
    // Width of the downstream free-slot count and the issued-lane count.
    localparam int FREE_W = $clog2(OUT_WIDTH + 1);

    // Payload of one lane (valid flag stripped).
    typedef logic [WIDTH-2:0] lane_t;
    // Raw lane as delivered by the FIFO: {valid, payload}.
    typedef logic [WIDTH-1:0] raw_lane_t;
    // Whole FIFO head bundle.
    typedef raw_lane_t [IN_DEPTH-1:0] bundle_t;

    // Number of consecutive set bits starting at bit 0. Anything past the
    // first clear bit is ignored.
    function automatic logic [CNT_W-1:0] lead_ones(input logic [IN_DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        logic             run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < IN_DEPTH; i++) begin
            run = run & v[i];
            if (run) begin
                n = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    // min(remaining, clamp(free), OUT_WIDTH), where the clamp limits the
    // downstream free count to OUT_WIDTH.
    function automatic logic [CNT_W-1:0] issue_count(input logic [CNT_W-1:0]  remaining,
                                                     input logic [FREE_W-1:0] free);
        logic [CNT_W-1:0] lim;
        lim = CNT_W'(free);
        if (lim > CNT_W'(OUT_WIDTH)) begin
            lim = CNT_W'(OUT_WIDTH);
        end
        return (remaining < lim) ? remaining : lim;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_if
// Description : Bundles the FIFO read port, flush, and downstream issue port
//               of fifo_drain.
//               slave  : the drain block (consumes FIFO, drives issue port)
//               master : the environment (FIFO + downstream)
//               Signals: fifo_empty, fifo_rd_data, fifo_rd_en, flush,
//                        out_free, out_valid, out_data, out_count, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_drain_if;
    import fifo_drain_pkg::*;

    logic                  fifo_empty;
    bundle_t               fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  flush;
    logic [FREE_W-1:0]     out_free;
    logic [OUT_WIDTH-1:0]  out_valid;
    lane_t [OUT_WIDTH-1:0] out_data;
    logic [FREE_W-1:0]     out_count;
    logic                  busy;

    modport master (
        output fifo_empty, fifo_rd_data, flush, out_free,
        input  fifo_rd_en, out_valid, out_data, out_count, busy
    );

    modport slave (
        input  fifo_empty, fifo_rd_data, flush, out_free,
        output fifo_rd_en, out_valid, out_data, out_count, busy
    );

endinterface
`default_nettype wire

// File: rtl/fifo_drain_lane_mux.sv
`default_nettype none
// ============================================================================
// Module      : drain_lane_mux
// Description : Selects OUT_WIDTH consecutive lanes from the held bundle
//               starting at hold_ptr. The first issue_n output lanes are
//               valid; the rest are driven to zero.
//               hold_data_i : held bundle payloads
//               hold_ptr_i  : first lane to issue
//               issue_n_i   : number of lanes issued this cycle
//               out_valid_o : prefix mask of issued lanes
//               out_data_o  : issued payloads (zero when not valid)
// Revision    : 1.0 - initial release
// ============================================================================
module drain_lane_mux
    import fifo_drain_pkg::*;
(
    input  lane_t [IN_DEPTH-1:0]  hold_data_i,
    input  logic  [CNT_W-1:0]     hold_ptr_i,
    input  logic  [CNT_W-1:0]     issue_n_i,
    output logic  [OUT_WIDTH-1:0] out_valid_o,
    output lane_t [OUT_WIDTH-1:0] out_data_o
);

    // One extra bit so hold_ptr + i cannot wrap for lanes beyond the bundle.
    logic [CNT_W:0] w_idx;

    always_comb begin
        out_valid_o = '0;
        out_data_o  = '0;
        w_idx       = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            w_idx = {1'b0, hold_ptr_i} + (CNT_W+1)'(i);
            if (CNT_W'(i) < issue_n_i) begin
                out_valid_o[i] = 1'b1;
                // Compare-based select keeps the index within IN_DEPTH-1.
                for (int j = 0; j < IN_DEPTH; j++) begin
                    if (w_idx == (CNT_W+1)'(j)) begin
                        out_data_o[i] = hold_data_i[j];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain
// Description : Read-side consumer for the bundle FIFO. Pops one IN_DEPTH-lane
//               bundle at a time and re-issues its leading valid lanes at up
//               to OUT_WIDTH lanes per cycle, limited by downstream free
//               slots. The next pop is requested in the same cycle the last
//               held lanes issue, so bundles stream without bubbles.
//               clock : rising-edge clock
//               reset : asynchronous, active-low
//               bus   : fifo_drain_if.slave (FIFO read port, flush, issue port)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain
    import fifo_drain_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    fifo_drain_if.slave  bus
);

    lane_t [IN_DEPTH-1:0] hold_data_q, hold_data_d;
    logic  [CNT_W-1:0]    hold_cnt_q,  hold_cnt_d;
    logic  [CNT_W-1:0]    hold_ptr_q,  hold_ptr_d;

    logic  [CNT_W-1:0]    w_remaining;
    logic  [CNT_W-1:0]    w_issue_raw;
    logic  [CNT_W-1:0]    w_issue_n;
    logic                 w_pop;
    logic  [IN_DEPTH-1:0] w_valid_bits;
    lane_t [IN_DEPTH-1:0] w_payload;

    // Split the FIFO head into lane-valid flags and payloads.
    always_comb begin
        w_valid_bits = '0;
        w_payload    = '0;
        for (int i = 0; i < IN_DEPTH; i++) begin
            w_valid_bits[i] = bus.fifo_rd_data[i][WIDTH-1];
            w_payload[i]    = bus.fifo_rd_data[i][WIDTH-2:0];
        end
    end

    // hold_ptr never passes hold_cnt, so this never underflows.
    assign w_remaining = hold_cnt_q - hold_ptr_q;
    assign w_issue_raw = issue_count(w_remaining, bus.out_free);
    // A flush cycle issues nothing.
    assign w_issue_n   = bus.flush ? '0 : w_issue_raw;

    // Pop when everything still held leaves this cycle. The reset term keeps
    // the request low while reset is asserted even with a non-empty FIFO.
    assign w_pop = reset & ~bus.fifo_empty & ~bus.flush & (w_remaining == w_issue_n);

    always_comb begin
        hold_data_d = hold_data_q;
        hold_cnt_d  = hold_cnt_q;
        hold_ptr_d  = hold_ptr_q;
        if (w_pop) begin
            hold_data_d = w_payload;
            hold_cnt_d  = lead_ones(w_valid_bits);
            hold_ptr_d  = '0;
        end else if (bus.flush) begin
            hold_cnt_d  = '0;
            hold_ptr_d  = '0;
        end else begin
            hold_ptr_d  = hold_ptr_q + w_issue_n;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_data_q <= '0;
            hold_cnt_q  <= '0;
            hold_ptr_q  <= '0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_ptr_q  <= hold_ptr_d;
        end
    end

    drain_lane_mux u_lane_mux (
        .hold_data_i (hold_data_q),
        .hold_ptr_i  (hold_ptr_q),
        .issue_n_i   (w_issue_n),
        .out_valid_o (bus.out_valid),
        .out_data_o  (bus.out_data)
    );

    assign bus.fifo_rd_en = w_pop;
    assign bus.out_count  = FREE_W'(w_issue_n);
    assign bus.busy       = (w_remaining != '0);

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain
// Description : Self-checking bench for fifo_drain. A queue-based model of
//               the FIFO and of the lanes still owed downstream is checked
//               against the DUT every cycle; directed vectors add literal
//               expectations at key cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain;
    import fifo_drain_pkg::*;

    logic clock;
    logic reset;

    fifo_drain_if bus ();

    fifo_drain dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    bundle_t fifo_q[$];   // FIFO contents, head at index 0
    lane_t   pend[$];     // lanes of the held bundle not yet issued

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bundle_t mk(input logic [IN_DEPTH-1:0] mask, input int base);
        bundle_t b;
        for (int i = 0; i < IN_DEPTH; i++) begin
            b[i] = {mask[i], lane_t'(base + i)};
        end
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Model + per-cycle compare
    // ------------------------------------------------------------------
    int m_n;
    bit m_pop;
    bit m_flush;
    int m_lim;

    always begin
        @(negedge clock);
        m_n     = 0;
        m_pop   = 1'b0;
        m_flush = bus.flush;
        if (reset) begin
            m_lim = (int'(bus.out_free) > OUT_WIDTH) ? OUT_WIDTH : int'(bus.out_free);
            m_n   = m_flush ? 0 : ((pend.size() < m_lim) ? pend.size() : m_lim);
            m_pop = (fifo_q.size() != 0) && !m_flush && (pend.size() == m_n);
        end
        chk("model out_count", int'(bus.out_count), m_n);
        chk("model fifo_rd_en", int'(bus.fifo_rd_en), int'(m_pop));
        chk("model busy", int'(bus.busy), int'(reset && pend.size() != 0));
        for (int i = 0; i < OUT_WIDTH; i++) begin
            chk($sformatf("model out_valid[%0d]", i), int'(bus.out_valid[i]), int'(i < m_n));
            chk($sformatf("model out_data[%0d]", i), int'(bus.out_data[i]),
                (i < m_n) ? int'(pend[i]) : 0);
        end
        @(posedge clock);
        if (!reset) begin
            pend.delete();
        end else if (m_pop) begin
            bundle_t b;
            bit      run;
            b   = fifo_q.pop_front();
            run = 1'b1;
            pend.delete();
            for (int i = 0; i < IN_DEPTH; i++) begin
                run = run & b[i][WIDTH-1];
                if (run) pend.push_back(b[i][WIDTH-2:0]);
            end
        end else if (m_flush) begin
            pend.delete();
        end else begin
            repeat (m_n) void'(pend.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // One cycle of stimulus; negative expectation arguments are skipped.
    // ------------------------------------------------------------------
    task automatic cyc(input int free, input bit fl, input int e_cnt, input int e_rd,
                       input int e_busy, input int e_d0);
        bus.out_free     = FREE_W'(free);
        bus.flush        = fl;
        bus.fifo_empty   = (fifo_q.size() == 0);
        bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        @(negedge clock);
        if (e_cnt  >= 0) chk("lit out_count",  int'(bus.out_count),  e_cnt);
        if (e_rd   >= 0) chk("lit fifo_rd_en", int'(bus.fifo_rd_en), e_rd);
        if (e_busy >= 0) chk("lit busy",       int'(bus.busy),       e_busy);
        if (e_d0   >= 0) chk("lit out_data0",  int'(bus.out_data[0]), e_d0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.flush        = 1'b0;
        bus.out_free     = '0;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = '0;

        // Reset held with a non-empty FIFO: no pop, nothing issued.
        fifo_q.push_back(mk(6'b111111, 1));
        cyc(3, 0, 0, 0, 0, -1);
        cyc(3, 0, 0, 0, 0, -1);
        reset = 1'b1;
        cyc(3, 0, 0, 1, 0, -1);          // first cycle after release pops A

        // Six lanes at three per cycle; pop of B overlaps the last issue.
        fifo_q.push_back(mk(6'b110111, 11));
        cyc(3, 0, 3, 0, 1, 1);
        cyc(3, 0, 3, 1, 1, 4);
        // B has length 3 (lane 3 invalid); it drains at once and C pops.
        fifo_q.push_back(mk(6'b001111, 21));
        cyc(3, 0, 3, 1, 1, 11);

        // Four-lane bundle with free slots 0,1,0,2,3.
        cyc(0, 0, 0, 0, 1, -1);
        cyc(1, 0, 1, 0, 1, 21);
        cyc(0, 0, 0, 0, 1, -1);
        cyc(2, 0, 2, 0, 1, 22);
        fifo_q.push_back(mk(6'b111111, 31));
        cyc(3, 0, 1, 1, 1, 24);

        // Flush with four lanes left while the FIFO holds a bundle.
        fifo_q.push_back(mk(6'b000000, 0));
        cyc(2, 0, 2, 0, 1, 31);
        cyc(3, 1, 0, 0, 1, -1);
        fifo_q.push_back(mk(6'b000011, 41));
        cyc(3, 0, 0, 1, 0, -1);          // idle after flush, zero-length pops
        cyc(3, 0, 0, 1, 0, -1);          // zero-length issues nothing, next pops
        cyc(3, 0, 2, 0, 1, 41);
        cyc(3, 0, 0, 0, 0, -1);

        // Mixed traffic, model-checked only.
        fifo_q.push_back(mk(6'b111111, 51));
        fifo_q.push_back(mk(6'b011111, 61));
        fifo_q.push_back(mk(6'b000001, 71));
        fifo_q.push_back(mk(6'b101011, 81));
        for (int k = 0; k < 16; k++) begin
            cyc((k * 7 + 1) % 4, (k == 9), -1, -1, -1, -1);
        end

        // Reset in the middle of a bundle.
        fifo_q.push_back(mk(6'b111111, 91));
        fifo_q.push_back(mk(6'b000111, 101));
        cyc(3, 0, -1, -1, -1, -1);
        cyc(1, 0, -1, -1, -1, -1);
        cyc(1, 0, -1, -1, -1, -1);
        reset = 1'b0;
        cyc(3, 0, 0, 0, 0, -1);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(3, 0, -1, -1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
